// File: rtl/riscv_trace_buffer.sv
// Trace capture FIFO for the core's register-writeback and data-memory observation ports.
// Up to two events per cycle are stored, memory first. A full buffer either drops new events or overwrites the oldest ones.
module riscv_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clr,
    input  logic [1:0]                 mode,
    input  logic                       stop_on_full,
    input  logic                       reg_write_sig,
    input  logic [4:0]                 reg_num,
    input  logic [DATA_W-1:0]          reg_data,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W-1:0]          rd_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [1:0]                 out_kind,
    output logic [ADDR_W-1:0]          out_idx,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] KIND_REG    = 2'b01;
    localparam logic [1:0] KIND_MEM_WR = 2'b10;
    localparam logic [1:0] KIND_MEM_RD = 2'b11;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          store [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic            overflow_q;

    logic            mem_ev;
    logic            reg_ev;
    entry_t          mem_entry;
    entry_t          reg_entry;
    entry_t          slot0_entry;
    entry_t          head_entry;
    logic [1:0]      n_ev;
    logic [1:0]      n_fit;
    logic [1:0]      n_excess;
    logic [1:0]      n_store;
    logic [1:0]      head_adv;
    logic [CW-1:0]   free_slots;
    logic [CW-1:0]   count_next;
    logic            pop;
    logic            normal;

    // NOTE: every signal assigned in always_comb receives a default first, so no path can infer a latch.
    always_comb begin
        mem_ev         = en & mode[1] & (wr | rd);
        reg_ev         = en & mode[0] & reg_write_sig;

        mem_entry      = '0;
        mem_entry.kind = wr ? KIND_MEM_WR : KIND_MEM_RD;
        mem_entry.idx  = addr;
        mem_entry.data = wr ? wr_data : rd_data;

        reg_entry      = '0;
        reg_entry.kind = KIND_REG;
        reg_entry.idx  = ADDR_W'(reg_num);
        reg_entry.data = reg_data;

        // Memory event always takes the first slot; the register event follows it.
        slot0_entry    = mem_ev ? mem_entry : reg_entry;

        n_ev           = 2'(mem_ev) + 2'(reg_ev);
        // Space is judged on the count at the start of the cycle; a same-cycle pop does not help.
        free_slots     = CW'(DEPTH) - count_q;
        n_fit          = (CW'(n_ev) > free_slots) ? free_slots[1:0] : n_ev;
        n_excess       = n_ev - n_fit;
        n_store        = stop_on_full ? n_fit : n_ev;

        pop            = (count_q != '0) & out_ready;
        // In overwrite mode each excess push retires one more old entry beyond the popped head.
        head_adv       = 2'(pop) + (stop_on_full ? 2'd0 : n_excess);
        count_next     = count_q + CW'(n_store) - CW'(head_adv);

        normal         = reset & ~clr;
    end

    // NOTE: the entry array carries no reset; pointers and count alone define which slots are meaningful.
    always_ff @(posedge clk) begin
        if (normal) begin
            if (n_store != 2'd0) begin
                store[tail] <= slot0_entry;
            end
            if (n_store == 2'd2) begin
                store[tail + PW'(1)] <= reg_entry;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            tail       <= tail + PW'(n_store);
            head       <= head + PW'(head_adv);
            count_q    <= count_next;
            if (n_excess != 2'd0) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        head_entry = '0;
        if (count_q != '0) begin
            head_entry = store[head];
        end
    end

    assign out_valid = (count_q != '0);
    assign out_kind  = head_entry.kind;
    assign out_idx   = head_entry.idx;
    assign out_data  = head_entry.data;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: a queue scoreboard tracks expected contents,
// a vector table covers single-cycle behaviour, and hand sequences cover fill/drain corners.
module tb_riscv_trace_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset, en, clr, stop_on_full;
    logic [1:0]        mode;
    logic              reg_write_sig, wr, rd, out_ready;
    logic [4:0]        reg_num;
    logic [31:0]       reg_data, wr_data, rd_data;
    logic [8:0]        addr;
    logic              out_valid, overflow;
    logic [1:0]        out_kind;
    logic [8:0]        out_idx;
    logic [31:0]       out_data;
    logic [4:0]        count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    logic m_ovf = 1'b0;

    typedef struct {
        logic        clr, en, stop, rws, wr, rd, ready;
        logic [1:0]  mode;
        logic [4:0]  reg_num;
        logic [31:0] reg_data, wr_data, rd_data;
        logic [8:0]  addr;
        int          exp_count;
        logic        exp_ovf;
        logic [1:0]  exp_kind;
        logic [8:0]  exp_idx;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    riscv_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
        .stop_on_full(stop_on_full), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_kind(out_kind),
        .out_idx(out_idx), .out_data(out_data), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic e, input logic [1:0] m,
                                input logic rws, input logic [4:0] rn, input logic [31:0] rdat,
                                input logic w, input logic r, input logic [8:0] a,
                                input logic [31:0] wd, input logic [31:0] rdd, input logic rdy,
                                input int ec, input logic eo, input logic [1:0] ek,
                                input logic [8:0] ei, input logic [31:0] ed);
        vec_t v;
        v.clr = c; v.en = e; v.mode = m; v.stop = 1'b1; v.rws = rws;
        v.reg_num = rn; v.reg_data = rdat; v.wr = w; v.rd = r; v.addr = a;
        v.wr_data = wd; v.rd_data = rdd; v.ready = rdy;
        v.exp_count = ec; v.exp_ovf = eo; v.exp_kind = ek; v.exp_idx = ei; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        clr = 0; en = 1; mode = 2'b11; stop_on_full = 1; reg_write_sig = 0;
        reg_num = 0; reg_data = 0; wr = 0; rd = 0; addr = 0;
        wr_data = 0; rd_data = 0; out_ready = 0;
    endtask

    // One clock: compare popped head against the scoreboard, advance the model, check state.
    task automatic cycle();
        ent_t evs[$];
        ent_t e;
        int   free_slots;
        if (reset && !clr && out_ready && sb.size() > 0) begin
            check("pop_kind", 64'(out_kind), 64'(sb[0].kind));
            check("pop_idx",  64'(out_idx),  64'(sb[0].idx));
            check("pop_data", 64'(out_data), 64'(sb[0].data));
        end
        if (en && mode[1] && (wr || rd)) begin
            e.kind = wr ? 2'b10 : 2'b11;
            e.idx  = addr;
            e.data = wr ? wr_data : rd_data;
            evs.push_back(e);
        end
        if (en && mode[0] && reg_write_sig) begin
            e.kind = 2'b01;
            e.idx  = {4'b0, reg_num};
            e.data = reg_data;
            evs.push_back(e);
        end
        @(posedge clk);
        if (!reset || clr) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            free_slots = DEPTH - sb.size();
            if (out_ready && sb.size() > 0) void'(sb.pop_front());
            for (int k = 0; k < evs.size(); k++) begin
                if (k >= free_slots) begin
                    m_ovf = 1'b1;
                    if (stop_on_full) continue;
                    if (sb.size() > 0) void'(sb.pop_front());
                end
                sb.push_back(evs[k]);
            end
        end
        #1;
        check("count",     64'(count),     64'(sb.size()));
        check("overflow",  64'(overflow),  64'(m_ovf));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() == 0) begin
            check("empty_out", {out_kind, out_idx, out_data}, 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        // Test 2, 5, 6 and extra single-cycle cases; each row is one clock.
        vecs[0]  = mk(1, 1, 2'b11, 0, 0, 0,        0, 0, 0,     0,     0,     0, 0, 0, 2'b00, 0,     0);
        vecs[1]  = mk(0, 1, 2'b11, 1, 5, 32'hA5,   0, 1, 9'h10, 0,     32'h77,0, 2, 0, 2'b11, 9'h10, 32'h77);
        vecs[2]  = mk(0, 1, 2'b11, 0, 0, 0,        0, 0, 0,     0,     0,     1, 1, 0, 2'b01, 9'h5,  32'hA5);
        vecs[3]  = mk(0, 1, 2'b11, 0, 0, 0,        0, 0, 0,     0,     0,     1, 0, 0, 2'b00, 0,     0);
        vecs[4]  = mk(0, 1, 2'b01, 0, 0, 0,        1, 1, 9'h3,  32'h33,32'h44,0, 0, 0, 2'b00, 0,     0);
        vecs[5]  = mk(0, 1, 2'b10, 0, 0, 0,        1, 1, 9'h3,  32'h33,32'h44,0, 1, 0, 2'b10, 9'h3,  32'h33);
        vecs[6]  = mk(0, 1, 2'b11, 0, 0, 0,        1, 0, 9'h4,  32'h55,0,     0, 2, 0, 2'b10, 9'h3,  32'h33);
        vecs[7]  = mk(0, 1, 2'b11, 1, 7, 32'h99,   0, 0, 0,     0,     0,     0, 3, 0, 2'b10, 9'h3,  32'h33);
        vecs[8]  = mk(1, 1, 2'b11, 1, 8, 32'h98,   0, 0, 0,     0,     0,     1, 0, 0, 2'b00, 0,     0);
        vecs[9]  = mk(0, 0, 2'b11, 1, 9, 32'h97,   1, 0, 9'h6,  32'h66,0,     0, 0, 0, 2'b00, 0,     0);
        vecs[10] = mk(0, 1, 2'b00, 1, 9, 32'h97,   1, 0, 9'h6,  32'h66,0,     0, 0, 0, 2'b00, 0,     0);
        vecs[11] = mk(0, 1, 2'b11, 1, 31,32'hDEAD, 1, 1, 9'h8,  32'h111,32'h222,0,2, 0, 2'b10, 9'h8,  32'h111);
        vecs[12] = mk(0, 1, 2'b11, 0, 0, 0,        0, 1, 9'h9,  0,     32'h333,1, 2, 0, 2'b01, 9'd31, 32'hDEAD);

        idle_inputs();
        reg_write_sig = 1; wr = 1; rd = 1; reg_data = 32'h1234; wr_data = 32'h5678;
        reset = 0;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_out",   {out_kind, out_idx, out_data}, 64'd0);
        reset = 1;
        idle_inputs();

        // Stop-on-full: 17 register writes keep the first 16.
        for (int pass = 0; pass < 2; pass++) begin
            idle_inputs();
            mode = 2'b01; stop_on_full = (pass == 0); reg_write_sig = 1; reg_num = 1;
            for (int i = 1; i <= 17; i++) begin
                reg_data = i;
                cycle();
            end
            reg_write_sig = 0;
            check("full_count", 64'(count), 64'd16);
            check("full_ovf",   64'(overflow), 64'd1);
            out_ready = 1;
            for (int i = 1; i <= 16; i++) begin
                check("drain_data", 64'(out_data), 64'(pass == 0 ? i : i + 1));
                cycle();
            end
            check("drained_count", 64'(count), 64'd0);
            out_ready = 0; clr = 1;
            cycle();
            clr = 0;
        end

        // One slot left and two events: the memory entry fits, the register entry is dropped.
        idle_inputs();
        mode = 2'b01; reg_write_sig = 1; reg_num = 2;
        for (int i = 0; i < 15; i++) begin
            reg_data = 32'h100 + i;
            cycle();
        end
        mode = 2'b11; wr = 1; addr = 9'h5; wr_data = 32'hBEEF; reg_data = 32'h16;
        cycle();
        wr = 0; reg_write_sig = 0;
        check("edge_count", 64'(count), 64'd16);
        check("edge_ovf",   64'(overflow), 64'd1);
        out_ready = 1;
        for (int i = 0; i < 16; i++) cycle();

        for (int i = 0; i < 13; i++) begin
            clr = vecs[i].clr; en = vecs[i].en; mode = vecs[i].mode;
            stop_on_full = vecs[i].stop; reg_write_sig = vecs[i].rws;
            reg_num = vecs[i].reg_num; reg_data = vecs[i].reg_data;
            wr = vecs[i].wr; rd = vecs[i].rd; addr = vecs[i].addr;
            wr_data = vecs[i].wr_data; rd_data = vecs[i].rd_data;
            out_ready = vecs[i].ready;
            cycle();
            check($sformatf("vec%0d_count", i), 64'(count),    64'(vecs[i].exp_count));
            check($sformatf("vec%0d_ovf", i),   64'(overflow), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_head", i),  {out_kind, out_idx, out_data},
                  {vecs[i].exp_kind, vecs[i].exp_idx, vecs[i].exp_data});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
